// File: rtl/div_if.sv
// div_if: start/annul handshake and operand/result bus between div_ctrl and the divider
interface div_if;
  logic start;
  logic annul;
  logic sgn;
  logic ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  modport master(output start, annul, sgn, op1, op2, input ready, result);
  modport slave(input start, annul, sgn, op1, op2, output ready, result);
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequences EX-stage DIV/DIVU through the iterative divider with flush abort and watchdog
module div_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int ABORT_MIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        flush,
  div_if.master       div,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, WRITE, ABORT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] acnt;
  logic expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign div.start = state == BUSY;
  assign div.annul = state == ABORT;
  // next state, stall and write strobe; flush outranks ready, ready outranks the watchdog
  always_comb begin
    state_n = state;
    stall = 1'b0;
    hilo_we = 1'b0;
    case (state)
      IDLE: begin
        stall = ex_div_valid && !flush;
        state_n = stall ? BUSY : IDLE;
      end
      BUSY: begin
        stall = 1'b1;
        state_n = flush ? ABORT : div.ready ? WRITE : expired ? ABORT : BUSY;
      end
      WRITE: begin
        hilo_we = !flush;
        state_n = IDLE;
      end
      ABORT: state_n = (int'(acnt) + 1 >= ABORT_MIN && !div.ready) ? IDLE : ABORT;
    endcase
  end
  // state, counters, latched operands, captured result and watchdog pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acnt <= '0;
      div.sgn <= 1'b0;
      div.op1 <= '0;
      div.op2 <= '0;
      hi <= '0;
      lo <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      timeout <= state == BUSY && !flush && !div.ready && expired;
      acnt <= state == ABORT ? acnt + 4'(acnt != '1) : '0;
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      if (state == IDLE && state_n == BUSY) begin
        div.sgn <= ex_div_signed;
        div.op1 <= ex_op1;
        div.op2 <= ex_op2;
      end
      if (state == BUSY && !flush && div.ready) begin
        hi <= div.result[63:32];
        lo <= div.result[31:0];
      end
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl against an arithmetic divider reference
module tb_div_ctrl;
  logic clk = 0, rst = 1;
  logic ex_div_valid = 0, ex_div_signed = 0, flush = 0;
  logic [31:0] ex_op1 = 0, ex_op2 = 0;
  logic stall, hilo_we, timeout;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  int lat = 34, dcnt = 0;
  bit never = 0, prev_we = 0;
  logic [63:0] exp_q[$];
  div_if dif();
  div_ctrl dut (.clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush), .div(dif), .stall(stall),
    .hilo_we(hilo_we), .hi(hi), .lo(lo), .timeout(timeout));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return 64'd0;
    if (s) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  // divider model: result ready lat cycles after start rises, unless it is told to hang
  always @(posedge clk) dcnt <= dif.start ? dcnt + 1 : 0;
  assign dif.ready = dif.start && dcnt == lat && !never;
  assign dif.result = ref_div(dif.sgn, dif.op1, dif.op2);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // monitor: every write strobe pops one expected result
  always @(negedge clk) begin
    if (hilo_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", {hi, lo}, 64'hx);
      else chk("hilo_data", {hi, lo}, exp_q.pop_front());
      if (prev_we) chk("we_back_to_back", 1, 0);
    end
    prev_we = hilo_we;
  end
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input int l, input bit wr);
    lat = l;
    ex_div_valid = 1;
    ex_div_signed = s;
    ex_op1 = a;
    ex_op2 = b;
    #1 chk("issue_stall", stall, 1);
    if (wr) exp_q.push_back(ref_div(s, a, b));
    @(negedge clk);
    ex_div_valid = 0;
    chk("start_t1", dif.start, 1);
    chk("latched_ops", {dif.sgn, dif.op1, dif.op2}, {s, a, b});
  endtask
  task automatic wait_write(input int l);
    int n = 1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("stall_len", n, l + 2);
    chk("we_pulse", hilo_we, 1);
    chk("start_gap", dif.start, 0);
    @(negedge clk);
  endtask
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input int l);
    issue(s, a, b, l, 1);
    wait_write(l);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outs", {dif.start, dif.annul, stall, hilo_we, timeout, hi, lo}, 0);
    chk("reset_ops", {dif.sgn, dif.op1, dif.op2}, 0);
    rst = 0;
    @(negedge clk);
    run(0, 100, 7, 34);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run(1, 32'hFFFFFFF9, 2, 34);
    chk("div_m7_2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run(0, 1234, 0, 1);
    chk("div_by_zero", {hi, lo}, 0);
    issue(0, 50, 5, 34, 0);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("abort_outs", {dif.annul, dif.start, stall}, 3'b100);
    @(negedge clk);
    chk("abort_hold", dif.annul, 1);
    @(negedge clk);
    chk("abort_exit", dif.annul, 0);
    run(0, 9, 3, 20);
    chk("divu_9_3", {hi, lo}, {32'd0, 32'd3});
    ex_div_valid = 1;
    flush = 1;
    #1 chk("valid_flush_stall", stall, 0);
    @(negedge clk);
    chk("valid_flush_no_start", dif.start, 0);
    ex_div_valid = 0;
    flush = 0;
    never = 1;
    issue(0, 1, 1, 34, 0);
    n = 1;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", n, 41);
    chk("timeout_outs", {stall, dif.annul, dif.start}, 3'b010);
    @(negedge clk);
    chk("timeout_pulse", timeout, 0);
    never = 0;
    repeat (3) @(negedge clk);
    chk("timeout_idle", {dif.annul, dif.start}, 0);
    issue(1, 77, 5, 34, 0);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_busy_outs", {dif.start, dif.annul, stall, hilo_we, timeout, hi, lo}, 0);
    chk("rst_busy_ops", {dif.sgn, dif.op1, dif.op2}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000));
      if (s && b == 32'hFFFFFFFF) b = 3;
      run(s, a, b, b == 0 ? 1 : $urandom_range(2, 34));
    end
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the EX stage and the iterative 32-bit divider. It accepts DIV/DIVU issues from EX and holds operands stable for the whole operation. It drives the divider's start/annul handshake, stalls the pipeline until the quotient and remainder are available, and produces a one-cycle HI/LO write. It also handles flush (exception) aborts and runs a watchdog that recovers from a divider that never reports ready.

## Interface
- TIMEOUT, 40: cycles in BUSY without `div_ready_i` before a forced abort (must be at least 36).
- ABORT_MIN, 2: minimum cycles spent in ABORT.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ex_div_valid_i  in  1  EX holds a DIV/DIVU instruction.
- ex_div_signed_i  in  1  1 = DIV, 0 = DIVU.
- ex_op1_i / ex_op2_i  in  32  dividend / divisor.
- flush_i  in  1  pipeline flush; squashes the in-flight divide.
- div_ready_i  in  1  divider result valid.
- div_result_i  in  64  {remainder[63:32], quotient[31:0]}.
- div_start_o  out  1  divider start; held high for the whole operation.
- div_annul_o  out  1  divider cancel.
- div_signed_o  out  1  latched signedness.
- div_op1_o / div_op2_o  out  32  latched operands.
- stall_o  out  1  freeze IF/ID/EX (combinational).
- hilo_we_o  out  1  one-cycle HI/LO write strobe.
- hi_o / lo_o  out  32  remainder / quotient.
- timeout_o  out  1  one-cycle pulse on a watchdog abort.

## Operation
- States: IDLE, BUSY, WRITE, ABORT. Reset enters IDLE.
- Reset values: every registered output is 0, including all operand, data and strobe outputs. The cycle counter and abort counter are 0.
- IDLE:
  - If `ex_div_valid_i` is high and `flush_i` is low: latch the signedness and both operands, clear the cycle counter, go to BUSY.
  - `stall_o` is 1 in this cycle.
  - If `flush_i` is high: stay in IDLE, no latch, `stall_o` = 0.
- BUSY:
  - `div_start_o` = 1, `div_annul_o` = 0, `stall_o` = 1.
  - The cycle counter increments every cycle.
  - Priority order: `flush_i` > `div_ready_i` > timeout.
  - `flush_i` → ABORT.
  - `div_ready_i` → register `hi_o` = `div_result_i[63:32]` and `lo_o` = `div_result_i[31:0]`, go to WRITE.
  - Counter reaches TIMEOUT−1 → pulse `timeout_o` next cycle, go to ABORT.
- WRITE:
  - `div_start_o` = 0. Dropping start returns the divider to free.
  - `hilo_we_o` = 1 unless `flush_i` is high; a flush suppresses the write.
  - `stall_o` = 0, so the instruction retires at the end of this cycle.
  - Always go to IDLE.
- ABORT:
  - `div_start_o` = 0, `div_annul_o` = 1, `stall_o` = 0, `hilo_we_o` = 0.
  - The abort counter increments.
  - Exit to IDLE when the abort counter ≥ ABORT_MIN and `div_ready_i` = 0.
  - While in ABORT, `ex_div_valid_i` is not accepted.
- Operand/data rules:
  - The latched operands and signedness stay constant from BUSY entry until the next issue.
  - `hi_o`/`lo_o` hold their value until the next capture.
  - Sign fix-up and divide-by-zero results come from the divider and pass through unchanged.
- `hilo_we_o` is never high in two consecutive cycles and never high outside WRITE.

## Timing
- Issue in cycle T → `div_start_o` high from T+1.
- Result latency: `div_ready_i` in cycle R → `hilo_we_o` with valid `hi_o`/`lo_o` in R+1. The stall releases in R+1.
- With the team divider (R = T+35 for a nonzero divisor), the pipeline stalls for 36 cycles.
- Back-to-back divides: the next DIV can issue in R+2. `div_start_o` is low for at least one cycle between operations.
- A flush in any BUSY cycle stops `hilo_we_o` from ever pulsing for that instruction. The earliest re-issue is ABORT_MIN+1 cycles after the flush cycle.
- `rst` during BUSY or ABORT: next cycle is IDLE with all outputs 0. `div_start_o` = 0 releases the divider.
- `ex_div_valid_i` and `flush_i` high in the same IDLE cycle: no issue.

## Test plan
- DIVU 100/7 → `div_start_o` high from T+1; one `hilo_we_o` pulse with `lo_o` = 0x0000000E, `hi_o` = 0x00000002; `stall_o` high for exactly the cycles from issue through R.
- DIV 0xFFFFFFF9/2, i.e. −7/2 → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF.
- Divisor 0 → `div_ready_i` arrives early; `hilo_we_o` writes the divider's zero result, `hi_o` = `lo_o` = 0.
- Flush 10 cycles after issue → ABORT with `div_annul_o` = 1; no `hilo_we_o`; a new DIVU 9/3 issued after IDLE yields `lo_o` = 3, `hi_o` = 0.
- Divider model never asserts ready → `timeout_o` pulses after TIMEOUT cycles in BUSY; `stall_o` drops; no write occurs.
- Two DIVU instructions back to back → two separate `hilo_we_o` pulses, with `div_start_o` low for at least one cycle between operations; `rst` asserted mid-BUSY → all outputs 0 next cycle.
